serial_subtractor: RTL

- Bit-serial, multi-cycle subtractor computing y = a - b - bin over WIDTH clock cycles, LSB first.
- It is the inverse-direction companion to the datapath's combinational 8-bit adder with carry-in (a + b + cin). It is used where area matters more than latency, e.g. compare and decrement paths in the processor datapath.
- Uses a start/done handshake with a busy indication. Produces the difference, the borrow-out and two status flags (zero, signed overflow).

---
 rtl/serial_subtractor.sv | 136 +++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: y = a - b - bin, one bit per clock, LSB first.
// start/done handshake; result, borrow-out, zero and signed-overflow flags
// update only at the commit edge and hold until the next commit.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_borrow;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_y;
  logic             r_bout;
  logic             r_zero;
  logic             r_ovf;

  logic             w_ai;
  logic             w_bi;
  logic             w_d;
  logic             w_borrow_nxt;
  logic             w_last;
  logic [WIDTH-1:0] w_res_nxt;

  // One full-subtractor bit slice on the current LSBs of the operand shifters
  assign w_ai         = r_a[0];
  assign w_bi         = r_b[0];
  assign w_d          = w_ai ^ w_bi ^ r_borrow;
  assign w_borrow_nxt = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_borrow);
  assign w_res_nxt    = {w_d, r_res[WIDTH-1:1]};
  assign w_last       = (r_count == LAST_BIT);

  assign ready = r_ready;
  assign busy  = r_busy;
  assign done  = r_done;
  assign y     = r_y;
  assign bout  = r_bout;
  assign zero  = r_zero;
  assign ovf   = r_ovf;

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_nxt = SHIFT;
      SHIFT:   if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register with handshake outputs registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == IDLE);
      r_busy  <= (w_state_nxt == SHIFT);
      r_done  <= (w_state_nxt == DONE);
    end
  end

  // Operand capture, bit-serial shifting and result commit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= '0;
      r_borrow <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_y      <= '0;
      r_bout   <= 1'b0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= bin;
            r_count  <= '0;
          end
        end
        SHIFT: begin
          r_res    <= w_res_nxt;
          r_a      <= {1'b0, r_a[WIDTH-1:1]};
          r_b      <= {1'b0, r_b[WIDTH-1:1]};
          r_borrow <= w_borrow_nxt;
          r_count  <= r_count + CNT_W'(1);
          // On the MSB slice the operand LSBs are the original sign bits
          if (w_last) begin
            r_y    <= w_res_nxt;
            r_bout <= w_borrow_nxt;
            r_zero <= (w_res_nxt == '0);
            r_ovf  <= (w_ai ^ w_bi) & (w_ai ^ w_d);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
